// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side fill endpoint: backing store, in-order read FIFO, modelled latency
// Optional macro MEM_RSP_RANDOM_LAT_EN adds 0-7 cycles of LFSR jitter to each read's due time.
package mem_responder_pkg;
  typedef logic [63:0] t_cl;
  localparam logic [1:0] MEM_RD = 2'd0;
  localparam logic [1:0] MEM_WR = 2'd1;

  typedef struct packed {
    logic        valid;
    logic [3:0]  id;
    logic [1:0]  op;
    logic [31:0] addr;
    t_cl         data;
  } t_mem_req_pkt;

  typedef struct packed {
    logic       valid;
    logic [3:0] id;
    t_cl        data;
  } t_mem_rsp_pkt;
endpackage

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int LATENCY   = 20,
  parameter int MEM_LINES = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  t_mem_req_pkt mem_req_pkt,
  output t_mem_rsp_pkt mem_rsp_pkt,
  output logic         busy,
  output logic         err_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(MEM_LINES);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  typedef struct packed {
    logic [3:0]    id;
    logic [AW-1:0] addr;
    logic [15:0]   due;
  } t_entry;

  t_entry        fifo_q [DEPTH];
  t_cl           store_q [MEM_LINES];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [15:0]   cyc_q, cyc_d;
  t_mem_rsp_pkt  rsp_q, rsp_d;
  logic          err_q, err_d;

  logic          req_rd, req_wr, push, pop, overflow;
  logic [AW-1:0] req_line;
  t_entry        head, new_entry;
  logic [15:0]   due_diff;
  logic [15:0]   jitter;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^mem_req_pkt.addr[31:AW];

`ifdef MEM_RSP_RANDOM_LAT_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end

  assign jitter = {13'd0, lfsr_q[2:0]};
`else
  assign jitter = 16'd0;
`endif

  always_comb begin
    req_rd   = mem_req_pkt.valid && (mem_req_pkt.op == MEM_RD);
    req_wr   = mem_req_pkt.valid && (mem_req_pkt.op == MEM_WR);
    req_line = mem_req_pkt.addr[AW-1:0];
    head     = fifo_q[rd_ptr_q];
    // Decide the pop one cycle early so the registered response lands exactly on due.
    due_diff = cyc_q + 16'd1 - head.due;
    pop      = (count_q != '0) && !due_diff[15];
    push     = req_rd && ((count_q != FULL) || pop);
    overflow = req_rd && !push;

    new_entry.id   = mem_req_pkt.id;
    new_entry.addr = req_line;
    new_entry.due  = cyc_q + 16'(LATENCY) + jitter;

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    cyc_d    = cyc_q + 16'd1;
    err_d    = err_q | overflow;

    rsp_d = '0;
    if (pop) begin
      rsp_d.valid = 1'b1;
      rsp_d.id    = head.id;
      // Write-first: a same-cycle write to the head line is forwarded.
      rsp_d.data  = (req_wr && (req_line == head.addr)) ? mem_req_pkt.data : store_q[head.addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cyc_q    <= '0;
      rsp_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cyc_q    <= cyc_d;
      rsp_q    <= rsp_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)   fifo_q[wr_ptr_q]  <= new_entry;
    if (req_wr) store_q[req_line] <= mem_req_pkt.data;
  end

  assign mem_rsp_pkt  = rsp_q;
  assign err_overflow = err_q;
  assign busy         = (count_q != '0) || rsp_q.valid;

`ifdef ASSERT
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!mem_req_pkt.valid || req_rd || req_wr);
      assert (!(overflow && !err_q));
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int  LAT  = 20;
  localparam t_cl CL_A = 64'hA5A5_0000_0000_0005;
  localparam t_cl CL_B = 64'hB0B0_1111_2222_0007;
  localparam t_cl CL_C = 64'hC0C0_3333_4444_0009;
  localparam t_cl CL_D = 64'hD0D0_5555_6666_0009;

  typedef struct {
    logic [3:0] id;
    t_cl        data;
    int         cyc;
  } t_exp;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  t_mem_req_pkt req;
  t_mem_rsp_pkt rsp;
  logic         busy;
  logic         err_overflow;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  t_exp exp_q[$];

  mem_responder #(.DEPTH(8), .LATENCY(LAT), .MEM_LINES(1024)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_req_pkt  (req),
    .mem_rsp_pkt  (rsp),
    .busy         (busy),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rsp.valid === 1'b1) begin
      t_exp e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got id %0h expected no response (cycle %0d)", rsp.id, cyc);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 64'(rsp.id), 64'(e.id));
        check("rsp_data", rsp.data, e.data);
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] id, input logic [31:0] addr, input t_cl data);
    req.valid = 1'b1;
    req.op    = op;
    req.id    = id;
    req.addr  = addr;
    req.data  = data;
    @(posedge clk);
    #1;
    req = '0;
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input t_cl expd, input bit accept);
    t_exp e;
    e.id   = id;
    e.data = expd;
    e.cyc  = cyc + LAT;
    if (accept) exp_q.push_back(e);
    send(MEM_RD, id, addr, '0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    idle(2);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(2);
  endtask

  initial begin
    req = '0;
    reset_n = 1'b0;
    idle(3);
    check("reset_rsp", 64'(rsp), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_err", 64'(err_overflow), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // single read, exact latency and busy window
    send(MEM_WR, 4'd0, 32'd5, CL_A);
    idle(1);
    rd(4'd3, 32'd5, CL_A, 1'b1);
    @(negedge clk);
    check("busy_first", 64'(busy), 64'd1);
    repeat (LAT - 1) @(negedge clk);
    check("busy_last", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_after", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    drain();

    // write then read of the same line
    send(MEM_WR, 4'd0, 32'd7, CL_B);
    rd(4'd1, 32'd7, CL_B, 1'b1);
    drain();

    // write landing on the head line in its pop cycle
    send(MEM_WR, 4'd0, 32'd9, CL_C);
    rd(4'd2, 32'd9, CL_D, 1'b1);
    idle(LAT - 2);
    send(MEM_WR, 4'd0, 32'd9, CL_D);
    drain();

    // eight back-to-back reads
    for (int i = 0; i < 8; i++) send(MEM_WR, 4'd0, 32'(16 + i), 64'h1000 + 64'(i));
    for (int i = 0; i < 8; i++) rd(4'(i), 32'(16 + i), 64'h1000 + 64'(i), 1'b1);
    drain();
    check("no_overflow_8", 64'(err_overflow), 64'd0);

    // ninth read while full is dropped
    for (int i = 0; i < 8; i++) rd(4'(i), 32'(16 + i), 64'h1000 + 64'(i), 1'b1);
    rd(4'd8, 32'd16, 64'h1000, 1'b0);
    check("overflow_set", 64'(err_overflow), 64'd1);
    drain();
    idle(5);
    check("overflow_sticky", 64'(err_overflow), 64'd1);
    do_reset();
    check("overflow_cleared", 64'(err_overflow), 64'd0);

    // push into a full FIFO in the cycle the head pops
    for (int i = 0; i < 8; i++) rd(4'(i), 32'(16 + i), 64'h1000 + 64'(i), 1'b1);
    idle(LAT - 1 - 8);
    rd(4'd8, 32'd20, 64'h1004, 1'b1);
    drain();
    check("no_overflow_pushpop", 64'(err_overflow), 64'd0);

    // reset with reads pending
    for (int i = 0; i < 4; i++) rd(4'(i), 32'(16 + i), 64'h1000 + 64'(i), 1'b1);
    idle(3);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_rsp_valid", 64'(rsp.valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    idle(3);
    reset_n = 1'b1;
    idle(LAT + 5);
    rd(4'd5, 32'd16, 64'h1000, 1'b1);
    drain();
    check("final_err", 64'(err_overflow), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
